mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit between the EX/MEM register and the MEM/WB register.
//  - Turns load/store requests into a variable-latency req/ack data-bus transaction.
//  - Produces byte/half lane strobes and sign/zero-extended load data (dout) for MEM/WB.
//  - Drives stall to the hazard unit, which deasserts the pipeline-register we, until the access completes.
// PARAMETERS
//  ADDR_W          32   data-bus address width
//  TIMEOUT_CYCLES  255  max BUSY cycles before abort; 0 = no timeout
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  mem_read     in   1       load in MEM stage
//  mem_write    in   1       store in MEM stage; wins over mem_read
//  mem_op       in   3       000 LB, 100 LBU, 001 LH, 101 LHU, 010 LW/SW; SB/SH use 000/001
//  addr         in   ADDR_W  byte address (ALU result)
//  wdata        in   32      store data, right-justified
//  dout         out  32      extended load data to MEM/WB dout_in
//  stall        out  1       1 = hold PC and all pipeline registers this cycle
//  misalign     out  1       one-cycle misaligned-access flag
//  bus_err      out  1       one-cycle timeout flag
//  dbus_req     out  1       bus request, held until ack
//  dbus_we      out  1       1 = write
//  dbus_addr    out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dbus_wstrb   out  4       byte enables (write only, 0 on read)
//  dbus_wdata   out  32      store data replicated across lanes
//  dbus_rdata   in   32      read data, valid with ack
//  dbus_ack     in   1       completion, sampled while dbus_req=1
// BEHAVIOUR
//  - Reset (async): state=IDLE, dout=0, counter=0; stall, misalign, bus_err and dbus_req are 0.
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE, no access: stall=0, dbus_req=0, dout holds the last value.
//  - IDLE, access: dbus_req=1, stall=1.
//    - ack in the same cycle -> DONE.
//    - otherwise -> BUSY.
//  - BUSY: dbus_req=1, stall=1, counter++.
//    - ack -> DONE.
//    - counter==TIMEOUT_CYCLES (nonzero) -> DONE with abort flag.
//  - DONE: stall=0 so MEM/WB captures dout; bus_err=1 if aborted; next state is always IDLE.
//    Returning to IDLE lets the next instruction enter MEM without re-issuing the current one.
//  - Latency: memory op = 1 stall cycle + ack wait; non-memory op = 0 cycles.
//  - Bus outputs (dbus_we, dbus_addr, dbus_wstrb, dbus_wdata) stay stable from IDLE-issue until ack.
//  - Load capture at ack: lane chosen by addr[1:0] (half by addr[1]).
//    - Sign-extend for 000/001, zero-extend for 100/101, word unchanged.
//    - Result registered into dout.
//    - On abort dout=0.
//  - Store: wstrb = 0001<<addr[1:0] (SB), 0011<<{addr[1],0} (SH), 1111 (SW).
//    - wdata replicated: {4{b}}, {2{h}}, w.
//    - dout unchanged, dbus_rdata ignored.
//  - mem_read and mem_write both 1: handled as a store.
//  - Reset mid-transaction: drops dbus_req at once, no completion reported.
//  - The bus tolerates a dropped request.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//   - Effect: no bus request, misalign=1 for one cycle in IDLE, stall=0, dout=0, FSM stays IDLE.
//  MISALIGN_TRAP_EN undefined:
//   - Low address bits are masked to natural alignment (half ignores addr[0], word ignores addr[1:0]).
//   - misalign tied 0.
// STRUCTURE
//  - Shared package mem_pkg: mem_op encodings (MEM_LB..MEM_W), state enum, strobe constants.
//  - Sub-module mem_lane_align (combinational): wstrb/wdata generation and load extract/extend.
//  - FSM and timeout counter live in mem_access_unit.
// TESTING
//  - LW addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> stall high 4 cycles; DONE dout=0xDEADBEEF, stall=0.
//  - LB addr=0x103, rdata=0x80FF_FF12 -> dout=0xFFFFFF80; same with LBU -> dout=0x00000080.
//  - SH addr=0x102, wdata=0x1234ABCD -> wstrb=1100, dbus_wdata=0xABCDABCD, dbus_we=1; dout unchanged.
//  - ack held 0, TIMEOUT_CYCLES=4 -> after 4 BUSY cycles DONE: bus_err=1, dout=0; next cycle IDLE, stall=0.
//  - LW addr=0x101 with MISALIGN_TRAP_EN -> misalign=1, dbus_req=0, stall=0; without it -> access at 0x100.
//  - rst_n low in BUSY -> dbus_req=0, stall=0, dout=0 immediately; a later access behaves normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: mem_op codes, FSM states, strobe patterns.
package mem_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_W   = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Size lives in op[1:0]; any code with op[1] set is treated as a word.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and load extract/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halves use only lane_i[1] and words ignore lane_i, which gives natural alignment.
    assign byte_v = rdata_i[8*lane_i +: 8];
    assign half_v = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        wstrb_o = STRB_W;
        wdata_o = wdata_i;
        ldata_o = rdata_i;
        case (op_i[1:0])
            2'b00: begin
                wstrb_o = STRB_B << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = op_i[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                wstrb_o = STRB_H << {lane_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = op_i[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus FSM with timeout, stall generation, load capture.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of masking the low bits.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       dout,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wstrb,
    output logic [31:0]       dbus_wdata,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dout_q, dout_d;
    logic             abort_q, abort_d;

    logic        access, mis;
    logic        stall_c, req_c, mis_c, err_c;
    logic [3:0]  strb;
    logic [31:0] ldata;

    assign access = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
    assign mis = is_misaligned(mem_op, addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    mem_lane_align u_align (
        .op_i    (mem_op),
        .lane_i  (addr[1:0]),
        .wdata_i (wdata),
        .rdata_i (dbus_rdata),
        .wstrb_o (strb),
        .wdata_o (dbus_wdata),
        .ldata_o (ldata)
    );

    // The hazard unit holds EX/MEM while stalled, so these stay stable until ack.
    assign dbus_we    = mem_write;
    assign dbus_addr  = {addr[ADDR_W-1:2], 2'b00};
    assign dbus_wstrb = mem_write ? strb : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        abort_d = abort_q;
        stall_c = 1'b0;
        req_c   = 1'b0;
        mis_c   = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (access && mis) begin
                    mis_c  = 1'b1;
                    dout_d = '0;
                end else if (access) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (dbus_ack) begin
                        state_d = DONE;
                        if (!mem_write) dout_d = ldata;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (dbus_ack) begin
                    state_d = DONE;
                    if (!mem_write) dout_d = ldata;
                end else if (TIMEOUT_CYCLES != 0 && cnt_d == CNT_LIM) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                    dout_d  = '0;
                end
            end
            DONE: begin
                err_c   = abort_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset kills the request immediately even if the pipeline still presents an access.
    assign stall    = stall_c & rst_n;
    assign dbus_req = req_c & rst_n;
    assign misalign = mis_c & rst_n;
    assign bus_err  = err_c & rst_n;
    assign dout     = dout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata;
    logic [31:0] dout;
    logic        stall, misalign, bus_err;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata, dbus_rdata;
    logic        dbus_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_op     (mem_op),
        .addr       (addr),
        .wdata      (wdata),
        .dout       (dout),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wstrb (dbus_wstrb),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dbus_ack  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_op = 3'b000;
        addr = '0; wdata = '0; dbus_rdata = '0; dbus_ack = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_dout", dout, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_req", {31'b0, dbus_req}, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'h0);
        chk("rst_err", {31'b0, bus_err}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // LW 0x100, ack on the 4th request cycle
        mem_read = 1'b1; mem_op = 3'b010; addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin dbus_ack = 1'b1; dbus_rdata = 32'hDEADBEEF; end
            @(negedge clk);
            chk($sformatf("lw_stall%0d", i), {31'b0, stall}, 32'h1);
            chk($sformatf("lw_req%0d", i), {31'b0, dbus_req}, 32'h1);
            tick();
        end
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("lw_done_dout", dout, 32'hDEADBEEF);
        chk("lw_done_stall", {31'b0, stall}, 32'h0);
        chk("lw_done_req", {31'b0, dbus_req}, 32'h0);
        tick();
        idle_bus();
        @(negedge clk);
        chk("idle_hold_dout", dout, 32'hDEADBEEF);
        chk("idle_stall", {31'b0, stall}, 32'h0);
        tick();

        // LB / LBU at 0x103 with immediate ack
        mem_read = 1'b1; mem_op = 3'b000; addr = 32'h103;
        dbus_rdata = 32'h80FFFF12; dbus_ack = 1'b1;
        @(negedge clk);
        chk("lb_stall", {31'b0, stall}, 32'h1);
        chk("lb_addr", dbus_addr, 32'h100);
        chk("lb_wstrb", {28'b0, dbus_wstrb}, 32'h0);
        tick();
        mem_op = 3'b100;
        @(negedge clk);
        chk("lb_dout", dout, 32'hFFFFFF80);
        chk("lb_done_stall", {31'b0, stall}, 32'h0);
        tick();
        @(negedge clk);
        chk("lbu_stall", {31'b0, stall}, 32'h1);
        tick();
        idle_bus();
        @(negedge clk);
        chk("lbu_dout", dout, 32'h00000080);
        tick();

        // SH 0x102
        mem_write = 1'b1; mem_op = 3'b001; addr = 32'h102; wdata = 32'h1234ABCD;
        @(negedge clk);
        chk("sh_wstrb", {28'b0, dbus_wstrb}, 32'hC);
        chk("sh_wdata", dbus_wdata, 32'hABCDABCD);
        chk("sh_we", {31'b0, dbus_we}, 32'h1);
        chk("sh_req", {31'b0, dbus_req}, 32'h1);
        tick();
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("sh_busy_wstrb", {28'b0, dbus_wstrb}, 32'hC);
        chk("sh_busy_stall", {31'b0, stall}, 32'h1);
        tick();
        idle_bus();
        @(negedge clk);
        chk("sh_dout_kept", dout, 32'h00000080);
        chk("sh_done_stall", {31'b0, stall}, 32'h0);
        tick();

        // timeout: ack never arrives
        mem_read = 1'b1; mem_op = 3'b010; addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", i), {31'b0, stall}, 32'h1);
            chk($sformatf("to_err%0d", i), {31'b0, bus_err}, 32'h0);
            tick();
        end
        @(negedge clk);
        chk("to_bus_err", {31'b0, bus_err}, 32'h1);
        chk("to_dout", dout, 32'h0);
        chk("to_done_stall", {31'b0, stall}, 32'h0);
        chk("to_done_req", {31'b0, dbus_req}, 32'h0);
        tick();
        idle_bus();
        @(negedge clk);
        chk("to_idle_stall", {31'b0, stall}, 32'h0);
        chk("to_idle_err", {31'b0, bus_err}, 32'h0);
        tick();

        // LW at misaligned 0x101
        mem_read = 1'b1; mem_op = 3'b010; addr = 32'h101;
        dbus_rdata = 32'h11223344; dbus_ack = 1'b1;
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        chk("mis_flag", {31'b0, misalign}, 32'h1);
        chk("mis_req", {31'b0, dbus_req}, 32'h0);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        tick();
        idle_bus();
        @(negedge clk);
        chk("mis_dout", dout, 32'h0);
        chk("mis_flag_clr", {31'b0, misalign}, 32'h0);
`else
        chk("mis_flag", {31'b0, misalign}, 32'h0);
        chk("mis_req", {31'b0, dbus_req}, 32'h1);
        chk("mis_addr", dbus_addr, 32'h100);
        tick();
        idle_bus();
        @(negedge clk);
        chk("mis_dout", dout, 32'h11223344);
`endif
        tick();

        // LH 0x102: upper half, sign-extended
        mem_read = 1'b1; mem_op = 3'b001; addr = 32'h102;
        dbus_rdata = 32'h80017FFF; dbus_ack = 1'b1;
        tick();
        idle_bus();
        @(negedge clk);
        chk("lh_dout", dout, 32'hFFFF8001);
        tick();

        // reset asserted while BUSY
        mem_read = 1'b1; mem_op = 3'b010; addr = 32'h300;
        tick();
        @(negedge clk);
        chk("rstb_busy_stall", {31'b0, stall}, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstb_req", {31'b0, dbus_req}, 32'h0);
        chk("rstb_stall", {31'b0, stall}, 32'h0);
        chk("rstb_dout", dout, 32'h0);
        tick();
        rst_n = 1'b1;
        idle_bus();
        tick();

        // SW after reset, immediate ack
        mem_write = 1'b1; mem_op = 3'b010; addr = 32'h304; wdata = 32'hCAFEF00D; dbus_ack = 1'b1;
        @(negedge clk);
        chk("sw_wstrb", {28'b0, dbus_wstrb}, 32'hF);
        chk("sw_wdata", dbus_wdata, 32'hCAFEF00D);
        chk("sw_addr", dbus_addr, 32'h304);
        chk("sw_stall", {31'b0, stall}, 32'h1);
        tick();
        idle_bus();
        @(negedge clk);
        chk("sw_done_stall", {31'b0, stall}, 32'h0);
        chk("sw_dout", dout, 32'h0);
        tick();

        // LHU 0x300 after reset: lower half, zero-extended
        mem_read = 1'b1; mem_op = 3'b101; addr = 32'h300;
        dbus_rdata = 32'h1234F00D; dbus_ack = 1'b1;
        tick();
        idle_bus();
        @(negedge clk);
        chk("lhu_dout", dout, 32'h0000F00D);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
